// File: rtl/ap_probe_pkg.sv
// Shared widths, record layout, tracker state and saturating helpers for the
// ap_start/ap_done handshake probe.
package ap_probe_pkg;

    localparam int NUM_MOD    = 5;
    localparam int TS_W       = 32;
    localparam int LAT_W      = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int DROP_W     = 16;
    localparam int ID_W       = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;
    localparam int REC_W      = ID_W + TS_W + 2 * LAT_W;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } trk_state_e;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [TS_W-1:0]  start_ts;
        logic [LAT_W-1:0] lat;
        logic [LAT_W-1:0] ii;
    } rec_t;

    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_W'(1);
    endfunction

    // Timestamp difference modulo 2^TS_W, clamped into a LAT_W field.
    function automatic logic [LAT_W-1:0] sat_sub(input logic [TS_W-1:0] a,
                                                 input logic [TS_W-1:0] b);
        logic [TS_W-1:0] d;
        d = a - b;
        if (|d[TS_W-1:LAT_W]) return '1;
        return d[LAT_W-1:0];
    endfunction

endpackage

// File: rtl/ap_hs_tracker.sv
// One monitored module: IDLE/RUN state machine, latency and II measurement,
// a one-entry record slot and a drop pulse when a completion finds it occupied.
module ap_hs_tracker
    import ap_probe_pkg::*;
#(
    parameter int ID = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             ap_start_i,
    input  logic             ap_done_i,
    input  logic [TS_W-1:0]  ts_i,
    input  logic             grant_i,
    output logic             slot_valid_o,
    output logic [REC_W-1:0] slot_rec_o,
    output logic             drop_o,
    output trk_state_e       state_o
);

    trk_state_e       state_q;
    logic [TS_W-1:0]  start_ts_q;
    logic [TS_W-1:0]  prev_start_q;
    logic             first_q;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] ii_q;
    logic             slot_valid_q;
    rec_t             slot_q;

    logic             start_ok;
    logic             complete;
    logic             slot_free;
    logic [LAT_W-1:0] ii_calc;
    rec_t             rec_d;

    always_comb begin
        ii_calc   = first_q ? '0 : sat_sub(ts_i, prev_start_q);
        start_ok  = (state_q == IDLE) && ap_start_i && enable_i;
        complete  = ((state_q == RUN) && ap_done_i) || (start_ok && ap_done_i);
        // A slot being granted this cycle is free to take the new record.
        slot_free = !slot_valid_q || grant_i;
        drop_o    = complete && !slot_free;
        rec_d.id  = ID_W'(ID);
        if (state_q == RUN) begin
            rec_d.start_ts = start_ts_q;
            rec_d.lat      = sat_inc(lat_q);
            rec_d.ii       = ii_q;
        end else begin
            rec_d.start_ts = ts_i;
            rec_d.lat      = '0;
            rec_d.ii       = ii_calc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            start_ts_q   <= '0;
            prev_start_q <= '0;
            first_q      <= 1'b1;
            lat_q        <= '0;
            ii_q         <= '0;
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
        end else begin
            if (grant_i) slot_valid_q <= 1'b0;
            if (complete && slot_free) begin
                slot_valid_q <= 1'b1;
                slot_q       <= rec_d;
            end
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        prev_start_q <= ts_i;
                        first_q      <= 1'b0;
                        if (!ap_done_i) begin
                            state_q    <= RUN;
                            start_ts_q <= ts_i;
                            ii_q       <= ii_calc;
                            lat_q      <= '0;
                        end
                    end
                end
                RUN: begin
                    lat_q <= sat_inc(lat_q);
                    if (ap_done_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign slot_valid_o = slot_valid_q;
    assign slot_rec_o   = slot_q;
    assign state_o      = state_q;

endmodule

// File: rtl/ap_ctrl_probe.sv
// Handshake probe top: free-running timestamp, per-module trackers, round-robin
// slot arbiter, record FIFO with a registered head and saturating drop counter.
module ap_ctrl_probe
    import ap_probe_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic               enable,
    input  logic [NUM_MOD-1:0] mon_ap_start,
    input  logic [NUM_MOD-1:0] mon_ap_done,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [REC_W-1:0]   rec_data,
    output logic [DROP_W-1:0]  drop_count,
    output logic               busy
);

    logic [TS_W-1:0]    ts_q;
    logic [ID_W-1:0]    rr_q;
    logic [DROP_W-1:0]  drop_q;
    logic               busy_q;

    logic [NUM_MOD-1:0] slot_valid;
    logic [NUM_MOD-1:0] grant_vec;
    logic [NUM_MOD-1:0] drop_vec;
    logic [NUM_MOD-1:0] run_vec;
    logic [REC_W-1:0]   slot_rec [NUM_MOD];
    trk_state_e         trk_state [NUM_MOD];

    for (genvar g = 0; g < NUM_MOD; g++) begin : g_trk
        ap_hs_tracker #(.ID(g)) u_trk (
            .clk_i        (ap_clk),
            .rst_ni       (ap_rst_n),
            .enable_i     (enable),
            .ap_start_i   (mon_ap_start[g]),
            .ap_done_i    (mon_ap_done[g]),
            .ts_i         (ts_q),
            .grant_i      (grant_vec[g]),
            .slot_valid_o (slot_valid[g]),
            .slot_rec_o   (slot_rec[g]),
            .drop_o       (drop_vec[g]),
            .state_o      (trk_state[g])
        );
        assign run_vec[g] = (trk_state[g] == RUN);
    end

    // FIFO: head register plus a circular array; total capacity FIFO_DEPTH.
    logic [REC_W-1:0]   head_q;
    logic               head_valid_q;
    logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_q;
    logic [FIFO_AW-1:0] rd_q;
    logic [FIFO_AW-1:0] mcnt_q;

    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               mem_we;
    logic [REC_W-1:0]   push_data;
    logic [ID_W-1:0]    gnt_idx;
    logic [DROP_W:0]    drop_sum;
    logic [DROP_W-1:0]  drop_d;

    always_comb begin
        fifo_full = head_valid_q && (mcnt_q == FIFO_AW'(FIFO_DEPTH - 1));
        pop       = head_valid_q && rec_ready;
        grant_vec = '0;
        gnt_idx   = '0;
        push      = 1'b0;
        push_data = '0;
        for (int k = 0; k < NUM_MOD; k++) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= NUM_MOD) idx = idx - NUM_MOD;
            if (!push && !fifo_full && slot_valid[idx]) begin
                push           = 1'b1;
                grant_vec[idx] = 1'b1;
                gnt_idx        = ID_W'(idx);
                push_data      = slot_rec[idx];
            end
        end
        // With an empty array the pushed record goes straight into the head.
        mem_we = push && !((pop || !head_valid_q) && (mcnt_q == '0));

        drop_sum = {1'b0, drop_q};
        for (int k = 0; k < NUM_MOD; k++) begin
            drop_sum = drop_sum + (DROP_W + 1)'(drop_vec[k]);
        end
        drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ts_q         <= '0;
            rr_q         <= '0;
            drop_q       <= '0;
            busy_q       <= 1'b0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            mcnt_q       <= '0;
        end else begin
            ts_q   <= ts_q + TS_W'(1);
            drop_q <= drop_d;
            busy_q <= |run_vec;
            if (push) begin
                rr_q <= (gnt_idx == ID_W'(NUM_MOD - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (pop || !head_valid_q) begin
                if (mcnt_q != '0) begin
                    head_q       <= mem_q[rd_q];
                    head_valid_q <= 1'b1;
                    rd_q         <= rd_q + 1'b1;
                    if (push) wr_q   <= wr_q + 1'b1;
                    else      mcnt_q <= mcnt_q - 1'b1;
                end else if (push) begin
                    head_q       <= push_data;
                    head_valid_q <= 1'b1;
                end else begin
                    head_valid_q <= 1'b0;
                end
            end else if (push) begin
                wr_q   <= wr_q + 1'b1;
                mcnt_q <= mcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (mem_we) mem_q[wr_q] <= push_data;
    end

    assign rec_valid  = head_valid_q;
    assign rec_data   = head_q;
    assign drop_count = drop_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ap_ctrl_probe.sv
// Bench for ap_ctrl_probe: timestamp model, invocation driver, record scoreboard.
module tb_ap_ctrl_probe;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [4:0]  mon_ap_start = '0;
  logic [4:0]  mon_ap_done = '0;
  logic        rec_valid;
  logic        rec_ready = 1'b1;
  logic [66:0] rec_data;
  logic [15:0] drop_count;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;
  int tb_ts;
  bit first_inv[5];
  int prev_s[5];
  logic [66:0] exp_q[$];

  ap_ctrl_probe dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .enable       (enable),
    .mon_ap_start (mon_ap_start),
    .mon_ap_done  (mon_ap_done),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_data     (rec_data),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  // clock / reset / timestamp model
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) tb_ts <= 0;
    else           tb_ts <= tb_ts + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [66:0] mk_rec(input int id, input int sts, input int lat, input int ii);
    return {3'(id), 32'(sts), 16'(lat), 16'(ii)};
  endfunction

  task automatic do_reset();
    ap_rst_n = 1'b0;
    mon_ap_start = '0;
    mon_ap_done = '0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) first_inv[i] = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
  endtask

  // Returns #1 after the edge that makes the DUT timestamp equal t.
  task automatic at_ts(input int t);
    int g;
    g = 0;
    while (tb_ts < t && g < 80000) begin
      @(posedge ap_clk);
      #1;
      g++;
    end
    if (tb_ts < t) check_eq("at_ts_timeout", tb_ts, t);
  endtask

  task automatic run_mod(input int m, input int s, input int d, input bit keep);
    int lat;
    int ii;
    lat = (d - s > 65535) ? 65535 : d - s;
    ii = first_inv[m] ? 0 : ((s - prev_s[m] > 65535) ? 65535 : s - prev_s[m]);
    first_inv[m] = 1'b0;
    prev_s[m] = s;
    at_ts(s);
    mon_ap_start[m] = 1'b1;
    at_ts(s + 1);
    mon_ap_start[m] = 1'b0;
    at_ts(d);
    mon_ap_done[m] = 1'b1;
    if (keep) exp_q.push_back(mk_rec(m, s, lat, ii));
    at_ts(d + 1);
    mon_ap_done[m] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge ap_clk);
      #1;
      g++;
    end
    repeat (5) @(posedge ap_clk);
    #1;
    check_eq(tag, exp_q.size(), 0);
  endtask

  // scoreboard: one pop per accepted record
  always @(negedge ap_clk) begin
    if (ap_rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rec_unexpected", exp_q.size(), 1);
      end else begin
        logic [66:0] e;
        e = exp_q.pop_front();
        check_eq("rec_data", rec_data, e);
      end
    end
  end

  initial begin
    #12;
    check_eq("rst_rec_valid", rec_valid, 0);
    check_eq("rst_rec_data", rec_data, 0);
    check_eq("rst_drop", drop_count, 0);
    check_eq("rst_busy", busy, 0);

    // single invocation on module 2, latency and output timing
    do_reset();
    run_mod(2, 10, 25, 1'b1);
    check_eq("t1_valid_ts26", rec_valid, 0);
    at_ts(27);
    check_eq("t1_valid_ts27", rec_valid, 1);
    drain("t1_drain");

    // two invocations on module 0, then a start blocked by enable=0
    do_reset();
    run_mod(0, 5, 13, 1'b1);
    run_mod(0, 40, 48, 1'b1);
    enable = 1'b0;
    at_ts(60);
    mon_ap_start[0] = 1'b1;
    at_ts(61);
    mon_ap_start[0] = 1'b0;
    at_ts(65);
    mon_ap_done[0] = 1'b1;
    at_ts(66);
    mon_ap_done[0] = 1'b0;
    enable = 1'b1;
    drain("t2_drain");

    // modules 1,3,4 complete together; enable drops while they run
    do_reset();
    at_ts(5);
    mon_ap_start = 5'b11010;
    at_ts(6);
    mon_ap_start = '0;
    at_ts(10);
    enable = 1'b0;
    at_ts(20);
    mon_ap_done = 5'b11010;
    exp_q.push_back(mk_rec(1, 5, 15, 0));
    exp_q.push_back(mk_rec(3, 5, 15, 0));
    exp_q.push_back(mk_rec(4, 5, 15, 0));
    at_ts(21);
    mon_ap_done = '0;
    enable = 1'b1;
    at_ts(22);
    check_eq("t3_valid_ts22", rec_valid, 1);
    at_ts(23);
    check_eq("t3_valid_ts23", rec_valid, 1);
    at_ts(24);
    check_eq("t3_valid_ts24", rec_valid, 1);
    at_ts(25);
    check_eq("t3_valid_ts25", rec_valid, 0);
    check_eq("t3_drop", drop_count, 0);
    drain("t3_drain");

    // back-pressure: FIFO fills, slot holds one, three completions drop
    do_reset();
    rec_ready = 1'b0;
    for (int k = 0; k < 20; k++) run_mod(0, 2 + 3 * k, 4 + 3 * k, k < 17);
    at_ts(70);
    check_eq("t4_drop", drop_count, 3);
    check_eq("t4_valid", rec_valid, 1);
    check_eq("t4_head_hold", rec_data, exp_q[0]);
    check_eq("t4_pending", exp_q.size(), 17);
    rec_ready = 1'b1;
    drain("t4_drain");
    check_eq("t4_drop_after", drop_count, 3);

    // latency saturation on a 70000-cycle run
    do_reset();
    at_ts(3);
    mon_ap_start[4] = 1'b1;
    at_ts(4);
    mon_ap_start[4] = 1'b0;
    at_ts(100);
    check_eq("t5_busy", busy, 1);
    at_ts(70003);
    mon_ap_done[4] = 1'b1;
    exp_q.push_back(mk_rec(4, 3, 65535, 0));
    at_ts(70004);
    mon_ap_done[4] = 1'b0;
    drain("t5_drain");
    check_eq("t5_idle", busy, 0);

    // reset mid-RUN with a record waiting
    do_reset();
    rec_ready = 1'b0;
    run_mod(1, 2, 6, 1'b1);
    at_ts(10);
    mon_ap_start = 5'b00110;
    at_ts(11);
    mon_ap_start = '0;
    at_ts(15);
    check_eq("t6_pre_valid", rec_valid, 1);
    check_eq("t6_pre_busy", busy, 1);
    ap_rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", rec_valid, 0);
    check_eq("t6_rst_data", rec_data, 0);
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_drop", drop_count, 0);
    do_reset();
    rec_ready = 1'b1;
    run_mod(1, 3, 7, 1'b1);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
